mem_port_arbiter: RTL and testbench

- Shares the single-port unified memory between the instruction-fetch requester (IF) and the load/store requester (LS) of the multicycle core.
- Sequences each access as a request/grant/ack transaction, latches address and data, and waits a fixed memory read latency.
- Returns read data with a one-cycle ACK pulse.
- Sits between the control FSM's fetch/mem states and the memory macro.

---
 rtl/ctrl_pkg.sv | 23 ++
 rtl/mem_lat_cnt.sv | 34 +++
 rtl/mem_port_arbiter.sv | 155 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
`default_nettype none
// ============================================================================
// ctrl_pkg : shared encodings for the memory port arbiter
// Rev 1.0
// ============================================================================
package ctrl_pkg;

    localparam int DEF_AW = 8;
    localparam int DEF_DW = 16;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        RSP    = 2'd3
    } state_t;

    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_LS = 1'b1;

endpackage
`default_nettype wire

// File: rtl/mem_lat_cnt.sv
`default_nettype none
// ============================================================================
// mem_lat_cnt : loadable down-counter with zero flag, times the read latency
// Rev 1.0
// ============================================================================
module mem_lat_cnt
    import ctrl_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic         CLK,
    input  logic         RST_F,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] r_count;

    always_ff @(posedge CLK or negedge RST_F) begin
        if (!RST_F) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_val;
        end else if (dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign zero = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// mem_port_arbiter : IF/LS request arbiter for the single-port unified memory
// Option macro MEM_ARB_RR_EN selects round-robin tie-breaking.   Rev 1.0
// ============================================================================
module mem_port_arbiter
    import ctrl_pkg::*;
#(
    parameter int AW      = DEF_AW,
    parameter int DW      = DEF_DW,
    parameter int MEM_LAT = 2
) (
    input  logic          CLK,
    input  logic          RST_F,
    input  logic          IF_REQ,
    input  logic [AW-1:0] IF_ADDR,
    output logic          IF_ACK,
    output logic [DW-1:0] IF_RDATA,
    input  logic          LS_REQ,
    input  logic          LS_WE,
    input  logic [AW-1:0] LS_ADDR,
    input  logic [DW-1:0] LS_WDATA,
    output logic          LS_ACK,
    output logic [DW-1:0] LS_RDATA,
    output logic          MEM_EN,
    output logic          MEM_WE,
    output logic [AW-1:0] MEM_ADDR,
    output logic [DW-1:0] MEM_WDATA,
    input  logic [DW-1:0] MEM_RDATA,
    output logic          BUSY,
    output logic          OWNER
);

    localparam logic [CNT_W-1:0] C_LAT_LOAD = CNT_W'(MEM_LAT - 1);

    state_t r_state;
    state_t w_state_nxt;
    logic   r_last_served;
    logic   r_after_rsp;
    logic   w_if_elig;
    logic   w_ls_elig;
    logic   w_grant;
    logic   w_grant_ls;
    logic   w_take;
    logic   w_cnt_load;
    logic   w_cnt_dec;
    logic   w_cnt_zero;
    logic   w_capture;
    logic   w_to_rsp;

    // The requester served in the previous RSP is masked for one IDLE cycle
    always_comb begin
        w_if_elig = IF_REQ && !(r_after_rsp && (r_last_served == OWN_IF));
        w_ls_elig = LS_REQ && !(r_after_rsp && (r_last_served == OWN_LS));
        w_grant   = w_if_elig || w_ls_elig;
`ifdef MEM_ARB_RR_EN
        w_grant_ls = w_ls_elig && (!w_if_elig || (r_last_served == OWN_IF));
`else
        w_grant_ls = w_ls_elig;
`endif
    end

    always_ff @(posedge CLK or negedge RST_F) begin
        if (!RST_F) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_load  = 1'b0;
        w_cnt_dec   = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_grant) w_state_nxt = ACCESS;
            end
            ACCESS: begin
                if (MEM_WE) begin
                    w_state_nxt = RSP;
                end else begin
                    w_cnt_load  = 1'b1;
                    w_state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (w_cnt_zero) begin
                    w_capture   = 1'b1;
                    w_state_nxt = RSP;
                end else begin
                    w_cnt_dec = 1'b1;
                end
            end
            RSP:     w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
        w_take   = (r_state == IDLE) && w_grant;
        w_to_rsp = (w_state_nxt == RSP);
    end

    mem_lat_cnt #(.W(CNT_W)) u_lat_cnt (
        .CLK      (CLK),
        .RST_F    (RST_F),
        .load     (w_cnt_load),
        .load_val (C_LAT_LOAD),
        .dec      (w_cnt_dec),
        .zero     (w_cnt_zero)
    );

    // Outputs are registered from next-state values so they line up with r_state
    always_ff @(posedge CLK or negedge RST_F) begin
        if (!RST_F) begin
            IF_ACK        <= 1'b0;
            LS_ACK        <= 1'b0;
            IF_RDATA      <= '0;
            LS_RDATA      <= '0;
            MEM_EN        <= 1'b0;
            MEM_WE        <= 1'b0;
            MEM_ADDR      <= '0;
            MEM_WDATA     <= '0;
            BUSY          <= 1'b0;
            OWNER         <= OWN_IF;
            r_last_served <= OWN_IF;
            r_after_rsp   <= 1'b0;
        end else begin
            r_after_rsp <= (r_state == RSP);
            if (r_state == RSP) r_last_served <= OWNER;

            MEM_EN <= w_take;
            if (w_take) begin
                OWNER     <= w_grant_ls;
                MEM_WE    <= w_grant_ls && LS_WE;
                MEM_ADDR  <= w_grant_ls ? LS_ADDR : IF_ADDR;
                MEM_WDATA <= w_grant_ls ? LS_WDATA : '0;
            end else begin
                MEM_WE    <= 1'b0;
                MEM_ADDR  <= '0;
                MEM_WDATA <= '0;
            end

            IF_ACK <= w_to_rsp && (OWNER == OWN_IF);
            LS_ACK <= w_to_rsp && (OWNER == OWN_LS);
            BUSY   <= (w_state_nxt != IDLE);

            if (w_capture) begin
                if (OWNER == OWN_LS) LS_RDATA <= MEM_RDATA;
                else                 IF_RDATA <= MEM_RDATA;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// tb_mem_port_arbiter : scoreboard bench for mem_port_arbiter (MEM_LAT 2 and 1)
// Rev 1.0
// ============================================================================
module tb_mem_port_arbiter;

    localparam int LAT = 2;

    logic        CLK = 1'b0;
    logic        RST_F;
    always #5 CLK = ~CLK;

    logic        if_req, ls_req, ls_we;
    logic [7:0]  if_addr, ls_addr;
    logic [15:0] ls_wdata;
    logic        if_ack, ls_ack, mem_en, mem_we, busy, owner;
    logic [15:0] if_rdata, ls_rdata, mem_wdata, mem_rdata;
    logic [7:0]  mem_addr;

    logic        d1_if_req, d1_ls_req, d1_ls_we;
    logic [7:0]  d1_if_addr, d1_ls_addr;
    logic [15:0] d1_ls_wdata;
    logic        d1_if_ack, d1_ls_ack, d1_mem_en, d1_mem_we, d1_busy, d1_owner;
    logic [15:0] d1_if_rdata, d1_ls_rdata, d1_mem_wdata, d1_mem_rdata;
    logic [7:0]  d1_mem_addr;

    mem_port_arbiter #(.AW(8), .DW(16), .MEM_LAT(LAT)) u_dut (
        .CLK(CLK), .RST_F(RST_F),
        .IF_REQ(if_req), .IF_ADDR(if_addr), .IF_ACK(if_ack), .IF_RDATA(if_rdata),
        .LS_REQ(ls_req), .LS_WE(ls_we), .LS_ADDR(ls_addr), .LS_WDATA(ls_wdata),
        .LS_ACK(ls_ack), .LS_RDATA(ls_rdata),
        .MEM_EN(mem_en), .MEM_WE(mem_we), .MEM_ADDR(mem_addr), .MEM_WDATA(mem_wdata),
        .MEM_RDATA(mem_rdata), .BUSY(busy), .OWNER(owner)
    );

    mem_port_arbiter #(.AW(8), .DW(16), .MEM_LAT(1)) u_dut1 (
        .CLK(CLK), .RST_F(RST_F),
        .IF_REQ(d1_if_req), .IF_ADDR(d1_if_addr), .IF_ACK(d1_if_ack), .IF_RDATA(d1_if_rdata),
        .LS_REQ(d1_ls_req), .LS_WE(d1_ls_we), .LS_ADDR(d1_ls_addr), .LS_WDATA(d1_ls_wdata),
        .LS_ACK(d1_ls_ack), .LS_RDATA(d1_ls_rdata),
        .MEM_EN(d1_mem_en), .MEM_WE(d1_mem_we), .MEM_ADDR(d1_mem_addr), .MEM_WDATA(d1_mem_wdata),
        .MEM_RDATA(d1_mem_rdata), .BUSY(d1_busy), .OWNER(d1_owner)
    );

    // Memory model: unwritten words have a fixed address-derived content
    bit   [15:0] mem [256];
    bit   [255:0] written;
    logic [15:0] p0, p1, d1_p0;

    function automatic logic [15:0] init_word(input logic [7:0] a);
        return (a == 8'h10) ? 16'hBEEF : {a, ~a};
    endfunction

    function automatic logic [15:0] rd(input logic [7:0] a);
        return written[a] ? mem[a] : init_word(a);
    endfunction

    always @(posedge CLK) begin
        if (mem_en && mem_we) begin
            mem[mem_addr]     <= mem_wdata;
            written[mem_addr] <= 1'b1;
        end
        p0    <= (mem_en && !mem_we) ? rd(mem_addr) : 16'hDEAD;
        p1    <= p0;
        d1_p0 <= (d1_mem_en && !d1_mem_we) ? rd(d1_mem_addr) : 16'hDEAD;
    end
    assign mem_rdata    = p1;
    assign d1_mem_rdata = d1_p0;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        bit          own;
        bit          is_wr;
        logic [15:0] data;
        int          cyc;
    } exp_t;
    exp_t sb[$];

    int checks;
    int failures;

    task automatic push_exp(input bit own, input bit is_wr, input logic [15:0] data, input int c);
        exp_t e;
        e.own = own; e.is_wr = is_wr; e.data = data; e.cyc = c;
        sb.push_back(e);
    endtask

    task automatic start_if(input logic [7:0] a, output int t);
        @(posedge CLK); #1;
        if_addr = a;
        if_req  = 1'b1;
        t = cyc;
    endtask

    // Waits for an ACK, compares it against the scoreboard head, then
    // spends one more cycle checking the ACK pulse width and BUSY.
    task automatic wait_ack(input bit hold, output int en_cnt, output logic [7:0] en_addr,
                            output bit en_we, output logic [15:0] en_wdata,
                            output bit own_stable, output logic busy_a1);
        exp_t        e;
        bit          got, seen_en, own_ls, own_ref;
        logic [15:0] obs;
        got = 0; seen_en = 0; own_ref = 0;
        en_cnt = 0; en_addr = '0; en_we = 0; en_wdata = '0; own_stable = 1; busy_a1 = 1'bx;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge CLK);
            if (mem_en) begin
                en_cnt++; en_addr = mem_addr; en_we = mem_we; en_wdata = mem_wdata;
                seen_en = 1; own_ref = owner;
            end else if (seen_en && owner !== own_ref) begin
                own_stable = 0;
            end
            if (if_ack || ls_ack) got = 1;
        end
        checks++;
        if (!got || sb.size() == 0) begin
            failures++;
            $display("FAIL ack_wait: got_ack=%0d queued=%0d, required ack with expectation", got, sb.size());
            return;
        end
        e = sb.pop_front();
        own_ls = ls_ack;
        checks++;
        if ((if_ack && ls_ack) || own_ls !== e.own) begin
            failures++;
            $display("FAIL ack_owner: if_ack=%0b ls_ack=%0b, required owner %0d", if_ack, ls_ack, e.own);
        end
        checks++;
        if (cyc !== e.cyc) begin
            failures++;
            $display("FAIL ack_cycle: got cycle %0d, required %0d", cyc, e.cyc);
        end
        if (!e.is_wr) begin
            obs = own_ls ? ls_rdata : if_rdata;
            checks++;
            if (obs !== e.data) begin
                failures++;
                $display("FAIL rdata: got %h, required %h", obs, e.data);
            end
        end
        if (!hold) begin
            if (own_ls) ls_req = 1'b0;
            else        if_req = 1'b0;
        end
        @(negedge CLK);
        busy_a1 = busy;
        checks++;
        if (if_ack || ls_ack) begin
            failures++;
            $display("FAIL ack_pulse: ack still high one cycle later (if=%0b ls=%0b), required 0", if_ack, ls_ack);
        end
    endtask

    task automatic test_reset();
        RST_F = 1'b0;
        repeat (3) @(negedge CLK);
        checks++;
        if ({if_ack, ls_ack, if_rdata, ls_rdata, mem_en, mem_we, mem_addr, mem_wdata, busy, owner} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: dut0 outputs not all zero, got busy=%b owner=%b mem_en=%b", busy, owner, mem_en);
        end
        checks++;
        if ({d1_if_ack, d1_ls_ack, d1_if_rdata, d1_ls_rdata, d1_mem_en, d1_mem_we, d1_mem_addr,
             d1_mem_wdata, d1_busy, d1_owner} !== '0) begin
            failures++;
            $display("FAIL reset_outputs_lat1: dut1 outputs not all zero, got busy=%b owner=%b", d1_busy, d1_owner);
        end
        RST_F = 1'b1;
        repeat (2) @(negedge CLK);
        checks++;
        if (busy !== 1'b0 || mem_en !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_reset: busy=%b mem_en=%b, required 0 0", busy, mem_en);
        end
    endtask

    task automatic test_single_read();
        int t, n; logic [7:0] a; bit we, os; logic [15:0] wd; logic b1;
        start_if(8'h10, t);
        push_exp(1'b0, 1'b0, 16'hBEEF, t + 2 + LAT);
        wait_ack(1'b0, n, a, we, wd, os, b1);
        checks++;
        if (n !== 1 || a !== 8'h10 || we !== 1'b0) begin
            failures++;
            $display("FAIL read_strobe: en_cycles=%0d addr=%h we=%b, required 1 10 0", n, a, we);
        end
    endtask

    task automatic test_store();
        int t, n; logic [7:0] a; bit we, os; logic [15:0] wd; logic b1;
        @(posedge CLK); #1;
        ls_we = 1'b1; ls_addr = 8'h22; ls_wdata = 16'h1234; ls_req = 1'b1;
        t = cyc;
        push_exp(1'b1, 1'b1, 16'h0000, t + 2);
        wait_ack(1'b0, n, a, we, wd, os, b1);
        ls_we = 1'b0;
        checks++;
        if (n !== 1 || a !== 8'h22 || we !== 1'b1 || wd !== 16'h1234) begin
            failures++;
            $display("FAIL store_strobe: en_cycles=%0d addr=%h we=%b wdata=%h, required 1 22 1 1234", n, a, we, wd);
        end
        start_if(8'h22, t);
        push_exp(1'b0, 1'b0, 16'h1234, t + 2 + LAT);
        wait_ack(1'b0, n, a, we, wd, os, b1);
    endtask

    task automatic test_simultaneous();
        int t, n; logic [7:0] a; bit we, os; logic [15:0] wd; logic b1;
        @(posedge CLK); #1;
        if_addr = 8'h10; ls_addr = 8'h30; ls_we = 1'b0;
        if_req = 1'b1; ls_req = 1'b1;
        t = cyc;
        push_exp(1'b1, 1'b0, 16'h30CF, t + 2 + LAT);
        push_exp(1'b0, 1'b0, 16'hBEEF, t + 2 + LAT + 3 + LAT);
        wait_ack(1'b0, n, a, we, wd, os, b1);
        checks++;
        if (b1 !== 1'b0) begin
            failures++;
            $display("FAIL masked_idle_busy: busy=%b in IDLE after RSP, required 0", b1);
        end
        wait_ack(1'b0, n, a, we, wd, os, b1);
        checks++;
        if (n !== 1 || a !== 8'h10) begin
            failures++;
            $display("FAIL second_grant: en_cycles=%0d addr=%h, required 1 10", n, a);
        end
    endtask

    task automatic test_back_to_back();
        int t, n; logic [7:0] a; bit we, os; logic [15:0] wd; logic b1; int extra;
        @(posedge CLK); #1;
        if_addr = 8'h10; ls_addr = 8'h30; ls_we = 1'b0;
        if_req = 1'b1; ls_req = 1'b1;
        t = cyc;
        for (int i = 0; i < 10; i++)
            push_exp((i % 2) == 0, 1'b0, ((i % 2) == 0) ? 16'h30CF : 16'hBEEF, t + 2 + LAT + i * (3 + LAT));
        for (int i = 0; i < 10; i++) begin
            wait_ack(i < 9, n, a, we, wd, os, b1);
            if (i == 8) ls_req = 1'b0;
        end
        extra = 0;
        repeat (5) begin
            @(negedge CLK);
            if (busy || mem_en) extra++;
        end
        checks++;
        if (extra !== 0) begin
            failures++;
            $display("FAIL b2b_extra_grant: %0d busy cycles after last ack, required 0", extra);
        end
    endtask

    task automatic test_hold_after_ack();
        int t, n; logic [7:0] a; bit we, os; logic [15:0] wd; logic b1; int extra;
        start_if(8'h10, t);
        push_exp(1'b0, 1'b0, 16'hBEEF, t + 2 + LAT);
        wait_ack(1'b1, n, a, we, wd, os, b1);
        if_req = 1'b0;
        checks++;
        if (b1 !== 1'b0) begin
            failures++;
            $display("FAIL hold_busy: busy=%b in cycle after ack, required 0", b1);
        end
        extra = 0;
        repeat (6) begin
            @(negedge CLK);
            if (busy || mem_en || if_ack) extra++;
        end
        checks++;
        if (extra !== 0) begin
            failures++;
            $display("FAIL duplicate_grant: %0d active cycles after held REQ, required 0", extra);
        end
    endtask

    task automatic test_lat1();
        int t, ack_c; bit got, seen, stable; exp_t e;
        got = 0; seen = 0; stable = 1; ack_c = -1;
        @(posedge CLK); #1;
        d1_ls_we = 1'b0; d1_ls_addr = 8'h30; d1_ls_req = 1'b1;
        t = cyc;
        push_exp(1'b1, 1'b0, 16'h30CF, t + 3);
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge CLK);
            if (d1_mem_en) seen = 1;
            if (seen && d1_owner !== 1'b1) stable = 0;
            if (d1_if_ack || d1_ls_ack) begin
                got = 1; ack_c = cyc;
            end
        end
        e = sb.pop_front();
        checks++;
        if (!got || d1_ls_ack !== 1'b1 || ack_c !== e.cyc) begin
            failures++;
            $display("FAIL lat1_ack: got=%0d ls_ack=%b cycle=%0d, required ls_ack at %0d", got, d1_ls_ack, ack_c, e.cyc);
        end
        checks++;
        if (d1_ls_rdata !== e.data) begin
            failures++;
            $display("FAIL lat1_rdata: got %h, required %h", d1_ls_rdata, e.data);
        end
        checks++;
        if (!seen || !stable) begin
            failures++;
            $display("FAIL lat1_owner: seen_en=%0d owner_stable=%0d, required 1 1", seen, stable);
        end
        d1_ls_req = 1'b0;
        repeat (2) @(negedge CLK);
    endtask

    task automatic test_reset_in_wait();
        int t, n, bad; logic [7:0] a; bit we, os; logic [15:0] wd; logic b1;
        start_if(8'h10, t);
        @(negedge CLK);
        @(negedge CLK);
        checks++;
        if (busy !== 1'b1 || mem_en !== 1'b1) begin
            failures++;
            $display("FAIL rst_pre_access: busy=%b mem_en=%b, required 1 1", busy, mem_en);
        end
        @(negedge CLK);
        RST_F = 1'b0;
        #1;
        checks++;
        if ({if_ack, ls_ack, if_rdata, ls_rdata, mem_en, mem_we, mem_addr, mem_wdata, busy, owner} !== '0) begin
            failures++;
            $display("FAIL async_reset: outputs not zero, got busy=%b if_rdata=%h ls_rdata=%h", busy, if_rdata, ls_rdata);
        end
        if_req = 1'b0;
        bad = 0;
        repeat (3) begin
            @(negedge CLK);
            if (if_ack || ls_ack || busy) bad++;
        end
        RST_F = 1'b1;
        repeat (4) begin
            @(negedge CLK);
            if (if_ack || ls_ack || busy) bad++;
        end
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("FAIL aborted_no_ack: %0d cycles with ack/busy after abort, required 0", bad);
        end
        start_if(8'h10, t);
        push_exp(1'b0, 1'b0, 16'hBEEF, t + 2 + LAT);
        wait_ack(1'b0, n, a, we, wd, os, b1);
    endtask

    initial begin
        if_req = 0; ls_req = 0; ls_we = 0; if_addr = '0; ls_addr = '0; ls_wdata = '0;
        d1_if_req = 0; d1_ls_req = 0; d1_ls_we = 0; d1_if_addr = '0; d1_ls_addr = '0; d1_ls_wdata = '0;
        checks = 0; failures = 0;
        test_reset();
        test_single_read();
        test_store();
        test_simultaneous();
        test_back_to_back();
        test_hold_after_ack();
        test_lat1();
        test_reset_in_wait();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
